// File: rtl/simple_dram_mc.sv
// simple_dram_mc: NUM_CH client request FIFOs, round-robin arbitrated onto one UMI port, with in-order read data steered back to per-channel response FIFOs.
// Optional per-channel UMI read/write counters are enabled by defining SIMPLE_DRAM_MC_STATS_EN.

module simple_dram_mc_fifo #(
    parameter int W     = 8,
    parameter int LOG_D = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         empty,
    output logic         full
);
    localparam int D = 1 << LOG_D;
    localparam logic [LOG_D-1:0] PTR_ONE = LOG_D'(1);
    localparam logic [LOG_D:0]   CNT_ONE = (LOG_D + 1)'(1);

    logic [W-1:0]     mem_q [D];
    logic [LOG_D-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LOG_D:0]   count_q, count_d;
    logic             do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == (LOG_D + 1)'(D));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem_q[rd_ptr_q];

    // Pointer and occupancy next-state
    always_comb begin
        wr_ptr_d = do_push ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
        rd_ptr_d = do_pop ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents need no reset because occupancy gates every read
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end
endmodule

module simple_dram_mc #(
    parameter int NUM_CH         = 2,
    parameter int LOG_REQ_DEPTH  = 9,
    parameter int LOG_RESP_DEPTH = 9,
    parameter int ADDR_W         = 64,
    parameter int DATA_W         = 512
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH-1:0]        mem_req_valid,
    input  logic [NUM_CH-1:0]        mem_req_is_write,
    input  logic [NUM_CH*ADDR_W-1:0] mem_req_addr,
    input  logic [NUM_CH*DATA_W-1:0] mem_req_data,
    output logic [NUM_CH-1:0]        mem_req_grant,
    output logic [NUM_CH-1:0]        mem_resp_valid,
    output logic [NUM_CH*DATA_W-1:0] mem_resp_data,
    input  logic [NUM_CH-1:0]        mem_resp_grant,
    output logic                     umi_req_valid,
    output logic                     umi_req_is_write,
    output logic [ADDR_W-1:0]        umi_req_addr,
    output logic [63:0]              umi_req_size,
    input  logic                     umi_req_grant,
    output logic                     umi_write_valid,
    output logic [DATA_W-1:0]        umi_write_data,
    input  logic                     umi_write_ready,
    input  logic                     umi_read_valid,
    input  logic [DATA_W-1:0]        umi_read_data,
    output logic                     umi_read_grant,
    output logic                     err_unexpected_read
`ifdef SIMPLE_DRAM_MC_STATS_EN
    ,
    output logic [NUM_CH*32-1:0]     stat_reads,
    output logic [NUM_CH*32-1:0]     stat_writes
`endif
);
    localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int REQ_W   = 1 + ADDR_W + DATA_W;
    localparam int TAG_LOG = LOG_RESP_DEPTH + ((NUM_CH > 1) ? $clog2(NUM_CH) : 0);
    localparam logic [LOG_RESP_DEPTH:0] CREDIT_MAX = {1'b1, {LOG_RESP_DEPTH{1'b0}}};
    localparam logic [LOG_RESP_DEPTH:0] CREDIT_ONE = (LOG_RESP_DEPTH + 1)'(1);

    logic [REQ_W-1:0]        req_head [NUM_CH];
    logic [NUM_CH-1:0]       req_empty, req_full, req_pop;
    logic [NUM_CH-1:0]       resp_empty, resp_push, resp_pop;
    logic [NUM_CH-1:0]       eligible, rd_issue, wr_issue;
    logic [LOG_RESP_DEPTH:0] credit_q [NUM_CH];
    logic [LOG_RESP_DEPTH:0] credit_d [NUM_CH];
    logic [CH_W-1:0]         rr_ptr_q, rr_ptr_d, sel, tag_head;
    logic [REQ_W-1:0]        sel_head;
    logic                    issue, found, tag_empty, tag_full_unused;
    logic                    err_q, err_d;
    int                      idx;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        simple_dram_mc_fifo #(.W(REQ_W), .LOG_D(LOG_REQ_DEPTH)) u_req_q (
            .clk       (clk),
            .rst       (rst),
            .push      (mem_req_valid[i]),
            .push_data ({mem_req_is_write[i], mem_req_addr[i*ADDR_W +: ADDR_W], mem_req_data[i*DATA_W +: DATA_W]}),
            .pop       (req_pop[i]),
            .head      (req_head[i]),
            .empty     (req_empty[i]),
            .full      (req_full[i])
        );

        simple_dram_mc_fifo #(.W(DATA_W), .LOG_D(LOG_RESP_DEPTH)) u_resp_q (
            .clk       (clk),
            .rst       (rst),
            .push      (resp_push[i]),
            .push_data (umi_read_data),
            .pop       (resp_pop[i]),
            .head      (mem_resp_data[i*DATA_W +: DATA_W]),
            .empty     (resp_empty[i]),
            .full      ()
        );

        assign mem_req_grant[i]  = mem_req_valid[i] && !req_full[i];
        assign mem_resp_valid[i] = !resp_empty[i];
        assign resp_pop[i]       = mem_resp_grant[i] && !resp_empty[i];
    end

    // Issued read tags, in UMI order; sized so every channel can hold a full credit window
    simple_dram_mc_fifo #(.W(CH_W), .LOG_D(TAG_LOG)) u_tag_q (
        .clk       (clk),
        .rst       (rst),
        .push      (issue && !umi_req_is_write),
        .push_data (sel),
        .pop       (umi_read_grant),
        .head      (tag_head),
        .empty     (tag_empty),
        .full      (tag_full_unused)
    );

    // Per-channel eligibility: writes need UMI write space, reads need a free response slot
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (req_empty[i]) begin
                eligible[i] = 1'b0;
            end else if (req_head[i][REQ_W-1]) begin
                eligible[i] = umi_write_ready;
            end else begin
                eligible[i] = (credit_q[i] < CREDIT_MAX);
            end
        end
    end

    // Round-robin pick: first eligible channel after the last granted one
    always_comb begin
        sel   = rr_ptr_q;
        found = 1'b0;
        idx   = 0;
        for (int k = 1; k <= NUM_CH; k++) begin
            idx   = (int'(rr_ptr_q) + k) % NUM_CH;
            sel   = (!found && eligible[idx]) ? CH_W'(idx) : sel;
            found = found | eligible[idx];
        end
    end

    assign sel_head         = req_head[sel];
    assign umi_req_valid    = |eligible;
    assign umi_req_is_write = sel_head[REQ_W-1];
    assign umi_req_addr     = sel_head[DATA_W +: ADDR_W];
    assign umi_req_size     = 64'd64;
    assign umi_write_data   = sel_head[DATA_W-1:0];
    assign issue            = umi_req_valid && umi_req_grant;
    assign umi_write_valid  = issue && umi_req_is_write;
    assign umi_read_grant   = umi_read_valid && !tag_empty;
    assign err_unexpected_read = err_q;

    // Issue/return steering, credit accounting and arbiter pointer next-state
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            req_pop[i]   = issue && (sel == CH_W'(i));
            rd_issue[i]  = req_pop[i] && !umi_req_is_write;
            wr_issue[i]  = req_pop[i] && umi_req_is_write;
            resp_push[i] = umi_read_grant && (tag_head == CH_W'(i));
            case ({rd_issue[i], resp_pop[i]})
                2'b10:   credit_d[i] = credit_q[i] + CREDIT_ONE;
                2'b01:   credit_d[i] = credit_q[i] - CREDIT_ONE;
                default: credit_d[i] = credit_q[i];
            endcase
        end
        rr_ptr_d = issue ? sel : rr_ptr_q;
        err_d    = err_q | (umi_read_valid && tag_empty);
    end

    // Control state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q <= CH_W'(NUM_CH - 1);
            err_q    <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                credit_q[i] <= '0;
            end
        end else begin
            rr_ptr_q <= rr_ptr_d;
            err_q    <= err_d;
            for (int i = 0; i < NUM_CH; i++) begin
                credit_q[i] <= credit_d[i];
            end
        end
    end

`ifdef SIMPLE_DRAM_MC_STATS_EN
    logic [31:0] stat_rd_q [NUM_CH];
    logic [31:0] stat_rd_d [NUM_CH];
    logic [31:0] stat_wr_q [NUM_CH];
    logic [31:0] stat_wr_d [NUM_CH];

    // Wrapping per-channel issue counters
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            stat_rd_d[i] = stat_rd_q[i] + (rd_issue[i] ? 32'd1 : 32'd0);
            stat_wr_d[i] = stat_wr_q[i] + (wr_issue[i] ? 32'd1 : 32'd0);
        end
    end

    // Counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                stat_rd_q[i] <= '0;
                stat_wr_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                stat_rd_q[i] <= stat_rd_d[i];
                stat_wr_q[i] <= stat_wr_d[i];
            end
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_stat
        assign stat_reads[i*32 +: 32]  = stat_rd_q[i];
        assign stat_writes[i*32 +: 32] = stat_wr_q[i];
    end
`else
    logic [NUM_CH-1:0] stat_issue_unused;
    assign stat_issue_unused = rd_issue | wr_issue;
`endif
endmodule

// File: tb/tb_simple_dram_mc.sv
// Bench for simple_dram_mc: a table of round-robin vectors plus hand sequences, with queue scoreboards for read data and write data.
module tb_simple_dram_mc;
    localparam int NCH = 2, AW = 64, DW = 64, LRQ = 2, LRS = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [NCH-1:0]    mem_req_valid, mem_req_is_write, mem_req_grant;
    logic [NCH*AW-1:0] mem_req_addr;
    logic [NCH*DW-1:0] mem_req_data, mem_resp_data;
    logic [NCH-1:0]    mem_resp_valid, mem_resp_grant;
    logic              umi_req_valid, umi_req_is_write, umi_req_grant;
    logic [AW-1:0]     umi_req_addr;
    logic [63:0]       umi_req_size;
    logic              umi_write_valid, umi_write_ready;
    logic [DW-1:0]     umi_write_data, umi_read_data;
    logic              umi_read_valid, umi_read_grant, err_unexpected_read;
`ifdef SIMPLE_DRAM_MC_STATS_EN
    logic [NCH*32-1:0] stat_reads, stat_writes;
`endif

    always #5 clk = ~clk;

    simple_dram_mc #(.NUM_CH(NCH), .LOG_REQ_DEPTH(LRQ), .LOG_RESP_DEPTH(LRS), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
        .mem_req_valid(mem_req_valid), .mem_req_is_write(mem_req_is_write),
        .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data), .mem_req_grant(mem_req_grant),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data), .mem_resp_grant(mem_resp_grant),
        .umi_req_valid(umi_req_valid), .umi_req_is_write(umi_req_is_write), .umi_req_addr(umi_req_addr),
        .umi_req_size(umi_req_size), .umi_req_grant(umi_req_grant),
        .umi_write_valid(umi_write_valid), .umi_write_data(umi_write_data), .umi_write_ready(umi_write_ready),
        .umi_read_valid(umi_read_valid), .umi_read_data(umi_read_data), .umi_read_grant(umi_read_grant),
        .err_unexpected_read(err_unexpected_read)
`ifdef SIMPLE_DRAM_MC_STATS_EN
        , .stat_reads(stat_reads), .stat_writes(stat_writes)
`endif
    );

    int n_cmp = 0, n_mis = 0;
    logic [AW-1:0]    pend_q [$];
    logic [DW-1:0]    exp_q [NCH][$];
    logic [AW+DW-1:0] exp_wr_q [$];

    typedef struct {
        logic [1:0]  v, wr;
        logic [63:0] a0, a1;
        logic        rdy, g;
        logic [1:0]  eg;
        logic        euv, ewr;
        logic [63:0] eaddr;
    } vec_t;
    vec_t tbl [10];

    function automatic logic [DW-1:0] wdat(input logic [AW-1:0] a);
        return a ^ 64'hC3C3_0F0F_5A5A_1234;
    endfunction

    function automatic logic [DW-1:0] rdat(input logic [AW-1:0] a);
        return {a[31:0], ~a[31:0]};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        mem_req_valid = '0; mem_req_is_write = '0; mem_req_addr = '0; mem_req_data = '0;
        mem_resp_grant = '0; umi_req_grant = 1'b0; umi_write_ready = 1'b0;
        umi_read_valid = 1'b0; umi_read_data = '0;
        cyc(n);
        rst = 1'b0;
        pend_q.delete();
        exp_wr_q.delete();
        for (int c = 0; c < NCH; c++) exp_q[c].delete();
    endtask

    task automatic push_req(input int ch, input logic wr, input logic [AW-1:0] a, input logic exp_g);
        mem_req_valid = '0;
        mem_req_valid[ch] = 1'b1;
        mem_req_is_write[ch] = wr;
        mem_req_addr[ch*AW +: AW] = a;
        mem_req_data[ch*DW +: DW] = wdat(a);
        if (exp_g) begin
            if (wr) exp_wr_q.push_back({a, wdat(a)});
            else exp_q[ch].push_back(rdat(a));
        end
        #1 check("req_grant", mem_req_grant[ch], exp_g);
        cyc(1);
        mem_req_valid = '0;
    endtask

    task automatic return_all();
        logic [AW-1:0] a;
        int guard;
        guard = 0;
        while (pend_q.size() > 0 && guard < 32) begin
            a = pend_q.pop_front();
            umi_read_valid = 1'b1;
            umi_read_data = rdat(a);
            #1 check("read_grant", umi_read_grant, 1'b1);
            cyc(1);
            umi_read_valid = 1'b0;
            guard++;
        end
    endtask

    task automatic drain();
        for (int c = 0; c < NCH; c++) begin
            while (exp_q[c].size() > 0) begin
                check($sformatf("resp_valid_ch%0d", c), mem_resp_valid[c], 1'b1);
                check($sformatf("resp_data_ch%0d", c), mem_resp_data[c*DW +: DW], exp_q[c].pop_front());
                mem_resp_grant[c] = 1'b1;
                cyc(1);
                mem_resp_grant[c] = 1'b0;
            end
        end
        check("resp_valid_idle", mem_resp_valid, 2'b00);
    endtask

    // UMI-side monitor: records issued reads, scores issued writes
    always @(negedge clk) begin
        if (!rst && umi_req_valid && umi_req_grant) begin
            if (umi_req_is_write) begin
                check("write_expected", exp_wr_q.size() > 0, 1'b1);
                if (exp_wr_q.size() > 0) check("write_addr_data", {umi_req_addr, umi_write_data}, exp_wr_q.pop_front());
                check("write_valid", umi_write_valid, 1'b1);
            end else begin
                pend_q.push_back(umi_req_addr);
                check("write_valid_on_read", umi_write_valid, 1'b0);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{2'b11, 2'b00, 64'h100, 64'h200, 1'b1, 1'b0, 2'b11, 1'b0, 1'b0, 64'h0};
        tbl[1] = '{2'b11, 2'b00, 64'h140, 64'h240, 1'b1, 1'b1, 2'b11, 1'b1, 1'b0, 64'h100};
        tbl[2] = '{2'b11, 2'b00, 64'h180, 64'h280, 1'b1, 1'b1, 2'b11, 1'b1, 1'b0, 64'h200};
        tbl[3] = '{2'b00, 2'b00, 64'h0,   64'h0,   1'b1, 1'b1, 2'b00, 1'b1, 1'b0, 64'h140};
        tbl[4] = '{2'b00, 2'b00, 64'h0,   64'h0,   1'b1, 1'b1, 2'b00, 1'b1, 1'b0, 64'h240};
        tbl[5] = '{2'b00, 2'b00, 64'h0,   64'h0,   1'b1, 1'b1, 2'b00, 1'b1, 1'b0, 64'h180};
        tbl[6] = '{2'b00, 2'b00, 64'h0,   64'h0,   1'b1, 1'b1, 2'b00, 1'b1, 1'b0, 64'h280};
        tbl[7] = '{2'b00, 2'b00, 64'h0,   64'h0,   1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 64'h0};
        tbl[8] = '{2'b01, 2'b01, 64'h300, 64'h0,   1'b1, 1'b1, 2'b01, 1'b0, 1'b0, 64'h0};
        tbl[9] = '{2'b00, 2'b00, 64'h0,   64'h0,   1'b1, 1'b1, 2'b00, 1'b1, 1'b1, 64'h300};

        // Reset state
        do_reset(2);
        check("rst_req_grant", mem_req_grant, 2'b00);
        check("rst_resp_valid", mem_resp_valid, 2'b00);
        check("rst_umi_req_valid", umi_req_valid, 1'b0);
        check("rst_umi_write_valid", umi_write_valid, 1'b0);
        check("rst_umi_read_grant", umi_read_grant, 1'b0);
        check("rst_err", err_unexpected_read, 1'b0);

        // Single-channel read with 5-cycle UMI latency
        umi_write_ready = 1'b1;
        push_req(0, 1'b0, 64'h40, 1'b1);
        check("single_uv", umi_req_valid, 1'b1);
        check("single_addr", umi_req_addr, 64'h40);
        check("single_size", umi_req_size, 64'd64);
        check("single_is_write", umi_req_is_write, 1'b0);
        umi_req_grant = 1'b1;
        cyc(1);
        umi_req_grant = 1'b0;
        check("single_uv_after", umi_req_valid, 1'b0);
        check("single_issued", pend_q.size(), 1);
        cyc(4);
        umi_read_valid = 1'b1;
        umi_read_data = rdat(pend_q.pop_front());
        #1 check("single_read_grant", umi_read_grant, 1'b1);
        check("single_lat_before", mem_resp_valid, 2'b00);
        cyc(1);
        umi_read_valid = 1'b0;
        check("single_lat_after", mem_resp_valid, 2'b01);
        drain();

        // Round-robin vectors
        do_reset(2);
        for (int r = 0; r < 10; r++) begin
            mem_req_valid = tbl[r].v;
            mem_req_is_write = tbl[r].wr;
            mem_req_addr = {tbl[r].a1, tbl[r].a0};
            mem_req_data = {wdat(tbl[r].a1), wdat(tbl[r].a0)};
            umi_write_ready = tbl[r].rdy;
            umi_req_grant = tbl[r].g;
            if (tbl[r].eg[0]) begin
                if (tbl[r].wr[0]) exp_wr_q.push_back({tbl[r].a0, wdat(tbl[r].a0)});
                else exp_q[0].push_back(rdat(tbl[r].a0));
            end
            if (tbl[r].eg[1]) begin
                if (tbl[r].wr[1]) exp_wr_q.push_back({tbl[r].a1, wdat(tbl[r].a1)});
                else exp_q[1].push_back(rdat(tbl[r].a1));
            end
            #1;
            check($sformatf("vec%0d_req_grant", r), mem_req_grant, tbl[r].eg);
            check($sformatf("vec%0d_umi_valid", r), umi_req_valid, tbl[r].euv);
            if (tbl[r].euv) begin
                check($sformatf("vec%0d_umi_addr", r), umi_req_addr, tbl[r].eaddr);
                check($sformatf("vec%0d_umi_is_write", r), umi_req_is_write, tbl[r].ewr);
            end
            check($sformatf("vec%0d_write_valid", r), umi_write_valid, tbl[r].euv && tbl[r].g && tbl[r].ewr);
            cyc(1);
        end
        mem_req_valid = '0;
        return_all();
        drain();

        // Credit stall with a 4-entry response window
        do_reset(2);
        umi_write_ready = 1'b1;
        umi_req_grant = 1'b1;
        for (int k = 0; k < 4; k++) push_req(0, 1'b0, 64'h1000 + 64'(k * 64), 1'b1);
        cyc(1);
        check("stall_issued4", pend_q.size(), 4);
        mem_req_valid = 2'b11;
        mem_req_is_write = 2'b00;
        mem_req_addr = {64'h2000, 64'h1100};
        mem_req_data = {wdat(64'h2000), wdat(64'h1100)};
        exp_q[0].push_back(rdat(64'h1100));
        exp_q[1].push_back(rdat(64'h2000));
        #1 check("stall_req_grant", mem_req_grant, 2'b11);
        cyc(1);
        mem_req_valid = '0;
        check("stall_ch1_uv", umi_req_valid, 1'b1);
        check("stall_ch1_addr", umi_req_addr, 64'h2000);
        cyc(1);
        check("stall_blocked", umi_req_valid, 1'b0);
        cyc(3);
        check("stall_blocked_hold", umi_req_valid, 1'b0);
        return_all();
        check("stall_blocked_after_return", umi_req_valid, 1'b0);
        check("stall_pop_data", mem_resp_data[DW-1:0], exp_q[0].pop_front());
        mem_resp_grant = 2'b01;
        cyc(1);
        mem_resp_grant = 2'b00;
        check("stall_release_uv", umi_req_valid, 1'b1);
        check("stall_release_addr", umi_req_addr, 64'h1100);
        cyc(1);
        return_all();
        drain();

        // Write gating on umi_write_ready, with request FIFO full boundary
        do_reset(2);
        umi_req_grant = 1'b1;
        for (int k = 0; k < 4; k++) push_req(1, 1'b1, 64'h3000 + 64'(k * 64), 1'b1);
        push_req(1, 1'b1, 64'h3100, 1'b0);
        check("wr_gated_mid", umi_req_valid, 1'b0);
        cyc(5);
        check("wr_gated", umi_req_valid, 1'b0);
        umi_write_ready = 1'b1;
        #1;
        check("wr_open_uv", umi_req_valid, 1'b1);
        check("wr_open_is_write", umi_req_is_write, 1'b1);
        check("wr_open_addr", umi_req_addr, 64'h3000);
        check("wr_open_wv", umi_write_valid, 1'b1);
        check("wr_open_data", umi_write_data, wdat(64'h3000));
        cyc(4);
        check("wr_all_issued", exp_wr_q.size(), 0);
        check("wr_idle_uv", umi_req_valid, 1'b0);

        // Unexpected read data
        do_reset(2);
        umi_read_valid = 1'b1;
        umi_read_data = 64'hDEAD_BEEF;
        #1 check("unexp_read_grant", umi_read_grant, 1'b0);
        check("unexp_err_before", err_unexpected_read, 1'b0);
        cyc(1);
        umi_read_valid = 1'b0;
        check("unexp_err_set", err_unexpected_read, 1'b1);
        cyc(5);
        check("unexp_err_sticky", err_unexpected_read, 1'b1);
        check("unexp_resp_valid", mem_resp_valid, 2'b00);
        do_reset(1);
        check("unexp_err_cleared", err_unexpected_read, 1'b0);

        // Reset with reads outstanding
        do_reset(2);
        umi_write_ready = 1'b1;
        umi_req_grant = 1'b1;
        for (int k = 0; k < 3; k++) push_req(0, 1'b0, 64'h4000 + 64'(k * 64), 1'b1);
        cyc(1);
        check("mid_issued3", pend_q.size(), 3);
        do_reset(1);
        check("mid_rst_uv", umi_req_valid, 1'b0);
        check("mid_rst_resp_valid", mem_resp_valid, 2'b00);
        check("mid_rst_read_grant", umi_read_grant, 1'b0);
        check("mid_rst_wv", umi_write_valid, 1'b0);
        umi_write_ready = 1'b1;
        umi_req_grant = 1'b1;
        for (int k = 0; k < 4; k++) push_req(0, 1'b0, 64'h5000 + 64'(k * 64), 1'b1);
        cyc(1);
        check("mid_post_rst_credit", pend_q.size(), 4);
        return_all();
        drain();
        umi_req_grant = 1'b0;
        umi_read_valid = 1'b1;
        umi_read_data = rdat(64'h4000);
        #1 check("mid_late_read_grant", umi_read_grant, 1'b0);
        cyc(1);
        umi_read_valid = 1'b0;
        check("mid_late_err", err_unexpected_read, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
